// File: rtl/pc_update.sv
// Next-PC stage: selects PC+4 or a registered branch target once per 10-phase instruction cycle.
// Optional taken/not-taken commit counters are enabled with `define PC_UPDATE_BRANCH_STATS_EN.
module pc_update #(
  parameter int unsigned           WIDTH        = 32,
  parameter int unsigned           PHASES       = 10,
  parameter int unsigned           SAMPLE_PHASE = 5,
  parameter int unsigned           COMMIT_PHASE = 9,
  parameter logic [WIDTH-1:0]      RESET_PC     = '0,
  parameter int unsigned           IMEM_BYTES   = 128
) (
  input  logic             clock,
  input  logic             reset,
  input  logic             pcsrc,
  input  logic [WIDTH-1:0] imm,
  output logic [WIDTH-1:0] pc_out,
  output logic [WIDTH-1:0] pc_plus4,
  output logic [WIDTH-1:0] branch_target,
  output logic [3:0]       phase,
  output logic             instr_done,
  output logic             halted,
  output logic             misaligned,
  output logic [15:0]      retired,
`ifdef PC_UPDATE_BRANCH_STATS_EN
  output logic [15:0]      taken_count,
  output logic [15:0]      not_taken_count,
`endif
  output logic             state_dbg
);

  typedef enum logic {RUN = 1'b0, HALT = 1'b1} state_t;

  localparam logic [3:0]       LAST_P   = 4'(PHASES - 1);
  localparam logic [3:0]       SAMPLE_P = 4'(SAMPLE_PHASE);
  localparam logic [3:0]       COMMIT_P = 4'(COMMIT_PHASE);
  localparam logic [WIDTH-1:0] PC_LIMIT = WIDTH'(IMEM_BYTES - 4);
  localparam logic [WIDTH-1:0] FOUR     = WIDTH'(4);

  state_t           state_q, state_d;
  logic [3:0]       phase_q, phase_d;
  logic [WIDTH-1:0] pc_q, pc_d;
  logic [WIDTH-1:0] target_q, target_d;
  logic             taken_q, taken_d;
  logic             done_q, done_d;
  logic             halted_q, halted_d;
  logic             mis_q, mis_d;
  logic [15:0]      retired_q, retired_d;

  logic [WIDTH-1:0] commit_next;
  logic             next_misaligned;
  logic             next_out_of_range;
  logic             retire;

`ifdef PC_UPDATE_BRANCH_STATS_EN
  logic [15:0]      tcnt_q, tcnt_d;
  logic [15:0]      ntcnt_q, ntcnt_d;
`endif

  // The phase counter free-runs in both states so it stays aligned with the other stages.
  always_comb begin
    phase_d = (phase_q == LAST_P) ? 4'd0 : phase_q + 4'd1;
  end

  always_comb begin
    commit_next       = taken_q ? target_q : (pc_q + FOUR);
    next_misaligned   = taken_q && (commit_next[1:0] != 2'b00);
    next_out_of_range = commit_next > PC_LIMIT;
  end

  always_comb begin
    state_d  = state_q;
    pc_d     = pc_q;
    target_d = target_q;
    taken_d  = taken_q;
    done_d   = 1'b0;
    halted_d = halted_q;
    mis_d    = mis_q;
    retire   = 1'b0;
    case (state_q)
      RUN: begin
        if (phase_q == SAMPLE_P) begin
          taken_d  = pcsrc;
          target_d = pc_q + (imm << 1);
        end
        if (phase_q == COMMIT_P) begin
          if (next_misaligned) begin
            mis_d    = 1'b1;
            halted_d = 1'b1;
            state_d  = HALT;
          end else begin
            // An out-of-range next PC still retires the current instruction.
            retire = 1'b1;
            done_d = 1'b1;
            if (next_out_of_range) begin
              halted_d = 1'b1;
              state_d  = HALT;
            end else begin
              pc_d = commit_next;
            end
          end
        end
      end
      HALT: begin
        state_d = HALT;
      end
      default: begin
        state_d = HALT;
      end
    endcase
    retired_d = (retire && (retired_q != 16'hFFFF)) ? retired_q + 16'd1 : retired_q;
  end

`ifdef PC_UPDATE_BRANCH_STATS_EN
  always_comb begin
    tcnt_d  = tcnt_q;
    ntcnt_d = ntcnt_q;
    if (retire) begin
      if (taken_q) begin
        if (tcnt_q != 16'hFFFF) tcnt_d = tcnt_q + 16'd1;
      end else begin
        if (ntcnt_q != 16'hFFFF) ntcnt_d = ntcnt_q + 16'd1;
      end
    end
  end

  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      tcnt_q  <= '0;
      ntcnt_q <= '0;
    end else begin
      tcnt_q  <= tcnt_d;
      ntcnt_q <= ntcnt_d;
    end
  end

  assign taken_count     = tcnt_q;
  assign not_taken_count = ntcnt_q;
`endif

  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      state_q   <= RUN;
      phase_q   <= 4'd0;
      pc_q      <= RESET_PC;
      target_q  <= '0;
      taken_q   <= 1'b0;
      done_q    <= 1'b0;
      halted_q  <= 1'b0;
      mis_q     <= 1'b0;
      retired_q <= 16'd0;
    end else begin
      state_q   <= state_d;
      phase_q   <= phase_d;
      pc_q      <= pc_d;
      target_q  <= target_d;
      taken_q   <= taken_d;
      done_q    <= done_d;
      halted_q  <= halted_d;
      mis_q     <= mis_d;
      retired_q <= retired_d;
    end
  end

  assign pc_out        = pc_q;
  assign pc_plus4      = pc_q + FOUR;
  assign branch_target = target_q;
  assign phase         = phase_q;
  assign instr_done    = done_q;
  assign halted        = halted_q;
  assign misaligned    = mis_q;
  assign retired       = retired_q;
  assign state_dbg     = state_q;

endmodule

// File: tb/tb_pc_update.sv
// Bench for pc_update: directed scenarios plus random branches, checked each cycle
// against an instruction-level reference model.
module tb_pc_update;

  logic        clock = 1'b0;
  logic        reset = 1'b1;
  logic        pcsrc = 1'b0;
  logic [31:0] imm   = '0;
  logic [31:0] pc_out, pc_plus4, branch_target;
  logic [3:0]  phase;
  logic        instr_done, halted, misaligned, state_dbg;
  logic [15:0] retired;
`ifdef PC_UPDATE_BRANCH_STATS_EN
  logic [15:0] taken_count, not_taken_count;
`endif

  int vectors = 0;
  int miscompares = 0;
  int done_pulses = 0;

  pc_update dut (
    .clock(clock), .reset(reset), .pcsrc(pcsrc), .imm(imm),
    .pc_out(pc_out), .pc_plus4(pc_plus4), .branch_target(branch_target),
    .phase(phase), .instr_done(instr_done), .halted(halted),
    .misaligned(misaligned), .retired(retired),
`ifdef PC_UPDATE_BRANCH_STATS_EN
    .taken_count(taken_count), .not_taken_count(not_taken_count),
`endif
    .state_dbg(state_dbg)
  );

  always #5 clock = ~clock;

  // Reference model: tracks the cycle position within an instruction and applies
  // the sample/commit rules directly.
  int          m_cyc;
  logic [31:0] m_pc, m_target;
  logic        m_taken, m_done, m_halted, m_mis;
  int          m_retired;

  always @(posedge clock or posedge reset) begin
    if (reset) begin
      m_cyc = 0; m_pc = 0; m_target = 0; m_taken = 0;
      m_done = 0; m_halted = 0; m_mis = 0; m_retired = 0;
    end else begin
      logic [31:0] nxt;
      m_done = 0;
      if (!m_halted && m_cyc == 5) begin
        m_taken  = pcsrc;
        m_target = m_pc + imm * 2;
      end
      if (!m_halted && m_cyc == 9) begin
        nxt = m_taken ? m_target : m_pc + 4;
        if (m_taken && (nxt % 4 != 0)) begin
          m_mis = 1; m_halted = 1;
        end else begin
          m_done = 1;
          if (m_retired < 65535) m_retired++;
          if (nxt > 124) m_halted = 1;
          else m_pc = nxt;
        end
      end
      m_cyc = (m_cyc + 1) % 10;
    end
  end

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    vectors++;
    if (act !== exp) begin
      miscompares++;
      $display("FAIL %s: got %0h expected %0h at t=%0t", name, act, exp, $time);
    end
  endtask

  task automatic compare_all();
    check("pc_out", pc_out, m_pc);
    check("pc_plus4", pc_plus4, m_pc + 32'd4);
    check("branch_target", branch_target, m_target);
    check("phase", {28'd0, phase}, m_cyc);
    check("instr_done", {31'd0, instr_done}, {31'd0, m_done});
    check("halted", {31'd0, halted}, {31'd0, m_halted});
    check("misaligned", {31'd0, misaligned}, {31'd0, m_mis});
    check("retired", {16'd0, retired}, m_retired);
    if (instr_done) done_pulses++;
  endtask

  // One clock: inputs already stable, compare on the falling edge.
  task automatic tick(input int n);
    for (int i = 0; i < n; i++) begin
      @(posedge clock);
      @(negedge clock);
      compare_all();
    end
  endtask

  task automatic do_reset();
    @(negedge clock);
    reset = 1'b1;
    #1;
    check("reset_pc", pc_out, 32'd0);
    check("reset_phase", {28'd0, phase}, 32'd0);
    check("reset_halted", {31'd0, halted}, 32'd0);
    check("reset_retired", {16'd0, retired}, 32'd0);
    @(negedge clock);
    reset = 1'b0;
    compare_all();
  endtask

  initial begin
    // Scenario 1: plain sequential stepping.
    pcsrc = 0; imm = 0;
    do_reset();
    done_pulses = 0;
    tick(30);
    check("seq_pc", pc_out, 32'd12);
    check("seq_retired", {16'd0, retired}, 32'd3);
    check("seq_pulses", done_pulses, 32'd3);

    // Scenario 2: backward branch from 8 to 0.
    do_reset();
    tick(20);
    check("pre_branch_pc", pc_out, 32'd8);
    pcsrc = 1; imm = 32'hFFFF_FFFC;
    tick(10);
    check("back_target", branch_target, 32'd0);
    check("back_pc", pc_out, 32'd0);
    check("back_retired", {16'd0, retired}, 32'd3);

    // Scenario 3: pcsrc high except at the sample phase is ignored.
    for (int i = 0; i < 10; i++) begin
      pcsrc = (m_cyc != 5);
      imm   = (m_cyc != 5) ? 32'd40 : 32'd0;
      tick(1);
    end
    check("glitch_pc", pc_out, 32'd4);

    // Scenario 4: misaligned taken target halts without retiring.
    pcsrc = 1; imm = 32'd1;
    tick(10);
    check("mis_target", branch_target, 32'd6);
    check("mis_flag", {31'd0, misaligned}, 32'd1);
    check("mis_pc", pc_out, 32'd4);
    check("mis_retired", {16'd0, retired}, 32'd4);
    check("mis_state", {31'd0, state_dbg}, 32'd1);
    tick(15);

    // Scenario 5: running off the end of instruction memory.
    pcsrc = 0; imm = 0;
    do_reset();
    tick(310);
    check("end_pc", pc_out, 32'd124);
    tick(10);
    check("end_halted", {31'd0, halted}, 32'd1);
    check("end_pc_held", pc_out, 32'd124);
    check("end_retired", {16'd0, retired}, 32'd32);
    pcsrc = 1; imm = 32'hFFFF_FFF0;
    tick(20);
    check("end_frozen_pc", pc_out, 32'd124);

    // Scenario 6: reset mid-instruction.
    pcsrc = 0; imm = 0;
    do_reset();
    tick(57);
    check("mid_pc", pc_out, 32'd20);
    check("mid_phase", {28'd0, phase}, 32'd7);
    do_reset();
    tick(20);
    check("after_reset_pc", pc_out, 32'd8);

    // Scenario 7: self-branch repeats in place.
    pcsrc = 1; imm = 0;
    tick(30);
    check("self_pc", pc_out, 32'd8);
    check("self_retired", {16'd0, retired}, 32'd5);

    // Random stimulus with occasional resets.
    for (int r = 0; r < 12; r++) begin
      do_reset();
      for (int c = 0; c < 300; c++) begin
        pcsrc = ($urandom_range(0, 2) == 0);
        case ($urandom_range(0, 9))
          0:       imm = $urandom();
          1:       imm = 32'($signed($urandom_range(0, 16)) - 8);
          default: imm = 32'($signed($urandom_range(0, 16) * 2) - 16);
        endcase
        tick(1);
      end
    end

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
